quad_speed_meter: RTL and testbench

QUAD_SPEED_METER -- requirements
Module: quad_speed_meter

---
 rtl/quad_pkg.sv | 41 ++++
 rtl/quad_input_filter.sv | 41 ++++
 rtl/quad_speed_meter.sv | 135 +++++++++++++
 tb/tb_quad_speed_meter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared step encoding, default parameters and Gray-code step decoder for the quadrature meter.
package quad_pkg;

  localparam int unsigned FILT_LEN_DEF   = 4;
  localparam int unsigned WIN_CYCLES_DEF = 50000;
  localparam int unsigned POS_W_DEF      = 16;

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_FWD  = 2'b01,
    STEP_ERR  = 2'b10,
    STEP_REV  = 2'b11
  } step_e;

  // Map {A,B} onto its position in the forward cycle 00->01->11->10.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    logic [1:0] idx;
    unique case (ab)
      2'b00:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Distance travelled round the cycle: 1 = forward, 3 = reverse, 2 = both bits flipped.
  function automatic step_e decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] diff;
    step_e      step;
    diff = gray_idx(cur_ab) - gray_idx(prev_ab);
    unique case (diff)
      2'd0:    step = STEP_NONE;
      2'd1:    step = STEP_FWD;
      2'd2:    step = STEP_ERR;
      default: step = STEP_REV;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchronizer followed by a persistence filter for one encoder channel.
module quad_input_filter import quad_pkg::*; #(
  parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_filt
);

  localparam logic [3:0] CntLast = 4'(FILT_LEN - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_filt;
  logic [3:0] r_cnt;

  // Reset seeds every stage with the live input so release never looks like an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= i_raw;
      r_sync2 <= i_raw;
      r_filt  <= i_raw;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CntLast) begin
        r_filt <= r_sync2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/quad_speed_meter.sv
// 4x quadrature decoder with position counter, sticky error flag and windowed speed measurement.
module quad_speed_meter import quad_pkg::*; #(
  parameter int unsigned FILT_LEN   = FILT_LEN_DEF,
  parameter int unsigned WIN_CYCLES = WIN_CYCLES_DEF,
  parameter int unsigned POS_W      = POS_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    clr_pos,
  output logic signed [POS_W-1:0] position,
  output logic                    dir,
  output logic signed [POS_W-1:0] speed,
  output logic                    speed_valid,
  output logic                    err
);

  localparam int unsigned WinW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam logic [WinW-1:0] WinLast = WinW'(WIN_CYCLES - 1);
  localparam logic signed [POS_W:0] SatMax = {2'b00, {(POS_W - 1){1'b1}}};
  localparam logic signed [POS_W:0] SatMin = -SatMax;

  logic                    w_filt_a;
  logic                    w_filt_b;
  logic [1:0]              w_ab;
  step_e                   w_step;
  logic signed [POS_W:0]   w_step_val;
  logic signed [POS_W:0]   w_acc_sum;
  logic signed [POS_W-1:0] w_acc_sat;

  logic [1:0]              r_prev_ab;
  logic [POS_W-1:0]        r_pos;
  logic                    r_dir;
  logic                    r_err;
  logic [WinW-1:0]         r_win;
  logic signed [POS_W-1:0] r_acc;
  logic signed [POS_W-1:0] r_speed;
  logic                    r_valid;

  quad_input_filter #(
    .FILT_LEN(FILT_LEN)
  ) u_filt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .i_raw (enc_a),
    .o_filt(w_filt_a)
  );

  quad_input_filter #(
    .FILT_LEN(FILT_LEN)
  ) u_filt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .i_raw (enc_b),
    .o_filt(w_filt_b)
  );

  assign w_ab   = {w_filt_a, w_filt_b};
  assign w_step = decode_step(r_prev_ab, w_ab);

  // Signed step value and saturating accumulation of the current window.
  always_comb begin
    w_step_val = '0;
    unique case (w_step)
      STEP_FWD: w_step_val = (POS_W + 1)'(1);
      STEP_REV: w_step_val = '1;
      default:  w_step_val = '0;
    endcase
    w_acc_sum = $signed({r_acc[POS_W-1], r_acc}) + w_step_val;
    if (w_acc_sum > SatMax) begin
      w_acc_sat = SatMax[POS_W-1:0];
    end else if (w_acc_sum < SatMin) begin
      w_acc_sat = SatMin[POS_W-1:0];
    end else begin
      w_acc_sat = w_acc_sum[POS_W-1:0];
    end
  end

  // Position, direction and error tracking; clr_pos overrides any coincident step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_ab <= {enc_a, enc_b};
      r_pos     <= '0;
      r_dir     <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      r_prev_ab <= w_ab;
      if (w_step == STEP_FWD) begin
        r_dir <= 1'b1;
      end else if (w_step == STEP_REV) begin
        r_dir <= 1'b0;
      end
      if (clr_pos) begin
        r_pos <= '0;
        r_err <= 1'b0;
      end else begin
        unique case (w_step)
          STEP_FWD: r_pos <= r_pos + POS_W'(1);
          STEP_REV: r_pos <= r_pos - POS_W'(1);
          STEP_ERR: r_err <= 1'b1;
          default:  ;
        endcase
      end
    end
  end

  // Free-running window; the terminal cycle folds in its own step before publishing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win   <= '0;
      r_acc   <= '0;
      r_speed <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_win == WinLast) begin
        r_win   <= '0;
        r_acc   <= '0;
        r_speed <= w_acc_sat;
        r_valid <= 1'b1;
      end else begin
        r_win <= r_win + WinW'(1);
        r_acc <= w_acc_sat;
      end
    end
  end

  assign position    = r_pos;
  assign dir         = r_dir;
  assign err         = r_err;
  assign speed       = r_speed;
  assign speed_valid = r_valid;

endmodule

// File: tb/tb_quad_speed_meter.sv
// Directed bench: decoder vector table plus hand sequences for speed, reset, glitch and wrap.
module tb_quad_speed_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enc_a;
  logic        enc_b;
  logic        clr_pos;
  logic [15:0] position;
  logic        dir;
  logic [15:0] speed;
  logic        speed_valid;
  logic        err;

  // Second instance with a one-sample filter so the 0x7FFF wrap is reachable quickly.
  logic        f_a;
  logic        f_b;
  logic        f_clr;
  logic [15:0] f_position;
  logic        f_dir;
  logic [15:0] f_speed;
  logic        f_speed_valid;
  logic        f_err;

  int checks = 0;
  int errors = 0;

  quad_speed_meter #(
    .FILT_LEN  (4),
    .WIN_CYCLES(100),
    .POS_W     (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .clr_pos    (clr_pos),
    .position   (position),
    .dir        (dir),
    .speed      (speed),
    .speed_valid(speed_valid),
    .err        (err)
  );

  quad_speed_meter #(
    .FILT_LEN  (1),
    .WIN_CYCLES(100),
    .POS_W     (16)
  ) dut_fast (
    .clk        (clk),
    .rst_n      (rst_n),
    .enc_a      (f_a),
    .enc_b      (f_b),
    .clr_pos    (f_clr),
    .position   (f_position),
    .dir        (f_dir),
    .speed      (f_speed),
    .speed_valid(f_speed_valid),
    .err        (f_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        a;
    logic        b;
    logic        clr;
    int          hold;
    logic [15:0] pos;
    logic        dir;
    logic        err;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] gray_ab(input int idx);
    logic [1:0] ab;
    case (idx & 3)
      0:       ab = 2'b00;
      1:       ab = 2'b01;
      2:       ab = 2'b11;
      default: ab = 2'b10;
    endcase
    return ab;
  endfunction

  initial begin
    int          g;
    int          fg;
    logic [15:0] prev_pos;

    // a, b, clr, hold, position, dir, err -- starts from {A,B}=10, position 0
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 10, 16'd1,    1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 2,  16'd0,    1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 10, 16'd1,    1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 10, 16'd2,    1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 10, 16'd3,    1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 10, 16'd4,    1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 10, 16'd5,    1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 10, 16'd6,    1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 10, 16'd7,    1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 10, 16'd8,    1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 10, 16'd7,    1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 10, 16'd7,    1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 2,  16'd0,    1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 10, 16'd1,    1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 10, 16'd1,    1'b1, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 10, 16'd2,    1'b1, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 10, 16'd1,    1'b0, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 10, 16'd0,    1'b0, 1'b1};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 10, 16'hFFFF, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 1'b1, 1'b1, 2,  16'd0,    1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 10, 16'd0,    1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 10, 16'd0,    1'b0, 1'b1};

    rst_n   = 1'b0;
    enc_a   = 1'b0;
    enc_b   = 1'b0;
    clr_pos = 1'b0;
    f_a     = 1'b0;
    f_b     = 1'b0;
    f_clr   = 1'b0;
    g       = 0;
    fg      = 0;
    tick(3);
    check("rst_position", position, 0);
    check("rst_dir", dir, 1);
    check("rst_speed", speed, 0);
    check("rst_valid", speed_valid, 0);
    check("rst_err", err, 0);

    // Window 1: 5 forward and 2 reverse steps -> speed 3 published at edge 100.
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      g = (k < 5) ? (g + 1) % 4 : (g + 3) % 4;
      {enc_a, enc_b} = gray_ab(g);
      tick(10);
    end
    check("win1_position", position, 3);
    for (int i = 71; i <= 100; i++) begin
      tick(1);
      check($sformatf("win1_valid_e%0d", i), speed_valid, (i == 100));
    end
    check("win1_speed", speed, 3);
    tick(1);
    check("win1_valid_drop", speed_valid, 0);
    check("win1_speed_hold", speed, 3);
    // Window 2 is empty.
    for (int i = 102; i <= 200; i++) begin
      tick(1);
      check($sformatf("win2_valid_e%0d", i), speed_valid, (i == 200));
    end
    check("win2_speed", speed, 0);

    // Window 3: one reverse step plus one illegal transition -> speed -1.
    g = (g + 3) % 4;
    {enc_a, enc_b} = gray_ab(g);
    tick(10);
    check("win3_rev_pos", position, 2);
    check("win3_rev_dir", dir, 0);
    g = (g + 2) % 4;
    {enc_a, enc_b} = gray_ab(g);
    tick(10);
    check("win3_ill_err", err, 1);
    check("win3_ill_pos", position, 2);
    tick(80);
    check("win3_valid", speed_valid, 1);
    check("win3_speed", speed, 16'hFFFF);

    // Reset at window cycle 50 with the raw inputs moving underneath it.
    tick(50);
    rst_n = 1'b0;
    enc_a = 1'b1;
    enc_b = 1'b0;
    tick(1);
    check("mid_rst_position", position, 0);
    check("mid_rst_dir", dir, 1);
    check("mid_rst_speed", speed, 0);
    check("mid_rst_valid", speed_valid, 0);
    check("mid_rst_err", err, 0);
    tick(2);
    rst_n = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      if (i == 10) begin
        check("release_no_step_pos", position, 0);
        check("release_no_step_err", err, 0);
      end
      check($sformatf("post_rst_valid_e%0d", i), speed_valid, (i == 100));
    end
    check("post_rst_speed", speed, 0);

    // Decoder table, with update latency checked on every 10-cycle step.
    prev_pos = 16'd0;
    for (int i = 0; i < NV; i++) begin
      enc_a   = vecs[i].a;
      enc_b   = vecs[i].b;
      clr_pos = vecs[i].clr;
      if (!vecs[i].clr && vecs[i].hold == 10) begin
        tick(6);
        check($sformatf("vec%0d_lat_hold", i), position, prev_pos);
        tick(1);
        check($sformatf("vec%0d_lat_upd", i), position, vecs[i].pos);
        tick(3);
      end else begin
        tick(vecs[i].hold);
      end
      check($sformatf("vec%0d_pos", i), position, vecs[i].pos);
      check($sformatf("vec%0d_dir", i), dir, vecs[i].dir);
      check($sformatf("vec%0d_err", i), err, vecs[i].err);
      prev_pos = vecs[i].pos;
    end
    clr_pos = 1'b0;

    // Glitch rejection from {A,B}=01.
    enc_a = 1'b0;
    enc_b = 1'b1;
    tick(10);
    check("gl_setup_pos", position, 16'hFFFF);
    clr_pos = 1'b1;
    tick(2);
    clr_pos = 1'b0;
    check("gl_clr_pos", position, 0);
    check("gl_clr_err", err, 0);
    enc_a = 1'b1;
    tick(3);
    enc_a = 1'b0;
    tick(10);
    check("gl3_pos", position, 0);
    check("gl3_err", err, 0);
    enc_a = 1'b1;
    tick(4);
    enc_a = 1'b0;
    tick(3);
    check("gl4_up_pos", position, 1);
    check("gl4_up_dir", dir, 1);
    tick(4);
    check("gl4_down_pos", position, 0);
    check("gl4_down_dir", dir, 0);
    check("gl4_err", err, 0);

    // clr_pos coinciding with the edge that carries a forward step.
    enc_a = 1'b1;
    enc_b = 1'b0;
    tick(10);
    check("cc_ill_err", err, 1);
    enc_a = 1'b0;
    tick(6);
    clr_pos = 1'b1;
    tick(1);
    clr_pos = 1'b0;
    check("cc_pos", position, 0);
    check("cc_err", err, 0);
    tick(5);
    check("cc_pos_after", position, 0);

    // Positive wrap on the fast instance: 32767 steps, then one more.
    f_clr = 1'b1;
    tick(1);
    f_clr = 1'b0;
    for (int i = 0; i < 32767; i++) begin
      fg = (fg + 1) % 4;
      {f_a, f_b} = gray_ab(fg);
      tick(1);
    end
    tick(3);
    check("wrap_max", f_position, 16'h7FFF);
    check("wrap_err", f_err, 0);
    fg = (fg + 1) % 4;
    {f_a, f_b} = gray_ab(fg);
    tick(4);
    check("wrap_min", f_position, 16'h8000);
    check("wrap_dir", f_dir, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
